pck_socket_fifo: RTL and testbench
==================================

# pck_socket_fifo

Socket buffer between two PCK processing modules. It terminates the module-to-socket link from the upstream module (accepts `data`/`dv`, returns `empty`) and drives the socket-to-module link to the downstream module (presents `data`/`dv`/`full`, consumes `rd_en`). It is a first-word-fall-through FIFO with occupancy reporting and sticky error flags.

## Interface
- `DATA_WIDTH`, 8, payload width; must match both attached links.
- `DEPTH`, 4, number of entries; power of two, ≥ 2.
- `AF_LEVEL`, DEPTH-1, almost-full threshold; 1 ≤ AF_LEVEL ≤ DEPTH.
- `CW`, $clog2(DEPTH)+1, derived, not overridable; width of `level`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_data` in DATA_WIDTH: upstream payload.
- `in_dv` in 1: upstream write strobe, qualified by `in_empty`.
- `in_empty` out 1: socket has at least one free slot; upstream may write.
- `out_data` out DATA_WIDTH: head-of-FIFO payload; forced to 0 when `out_dv`=0.
- `out_dv` out 1: head entry valid (FIFO non-empty).
- `out_full` out 1: occupancy == DEPTH.
- `out_rd_en` in 1: downstream pop, qualified by `out_dv`.
- `level` out CW: current occupancy, 0..DEPTH.
- `almost_full` out 1: level ≥ AF_LEVEL.
- `ovf` out 1: sticky; write attempted while `in_empty`=0.
- `udf` out 1: sticky; pop attempted while `out_dv`=0.

## Operation
- Storage: DEPTH-entry register array, write pointer `wp`, read pointer `rp` (log2 DEPTH bits, natural wrap), occupancy counter `cnt` (CW bits).
- Write accepted: `wr = in_dv & in_empty`. Stores `in_data` at `wp`, `wp` +1 mod DEPTH.
- Pop accepted: `rd = out_rd_en & out_dv`. `rp` +1 mod DEPTH.
- `cnt` next: +1 on wr only, −1 on rd only, unchanged on both or neither. It never exceeds DEPTH and never goes below 0.
- Flags are decoded from registered `cnt` only: `in_empty` = cnt<DEPTH, `out_dv` = cnt≠0, `out_full` = cnt==DEPTH, `almost_full` = cnt≥AF_LEVEL, `level` = cnt.
- There is no combinational path from `in_dv` or `out_rd_en` to any output.
- `out_data` = mem[rp] when cnt≠0, else 0.
- Rejected write (`in_dv`=1, `in_empty`=0): data dropped, `ovf` set. Rejected pop (`out_rd_en`=1, `out_dv`=0): no state change, `udf` set.
- `ovf` and `udf` clear only on reset.
- Order preserved; no reordering or duplication.

## Timing
- Reset (`rst`=0, asynchronous, any time): `wp`=`rp`=`cnt`=0, `ovf`=`udf`=0. Outputs: `in_empty`=1, `out_dv`=0, `out_full`=0, `almost_full`=0, `level`=0, `out_data`=0. Memory contents are not reset. Any in-flight write or pop is discarded.
- Write-to-read latency: a word written at edge N is on `out_data` with `out_dv`=1 after edge N when the FIFO was empty (visible in cycle N+1).
- Pop: `out_data` advances to the next entry after the pop edge, or goes to 0 if the FIFO is emptied.
- Simultaneous write and pop at 0<cnt<DEPTH: both accepted, `cnt` unchanged, pointers both advance.
- Full with simultaneous write and pop: the pop is accepted and the write is rejected (`in_empty` was 0). `cnt` becomes DEPTH−1 and `ovf` is set.
- Empty with simultaneous write and pop: the write is accepted and the pop is rejected. `cnt` becomes 1 and `udf` is set.
- Pointer wrap: after DEPTH writes `wp` returns to 0. Full and empty are distinguished by `cnt`, not by pointer compare.
- Throughput: one write and one pop per cycle sustained.

## Test plan
- Reset values: hold `rst`=0 with random inputs → all outputs at reset values listed above; release, no stimulus → `in_empty`=1, `level`=0, `out_dv`=0 stable.
- Fill and drain, DEPTH=4: write 0x11,0x22,0x33,0x44 on consecutive cycles.
  - After the 1st edge: `out_dv`=1, `out_data`=0x11. After the 3rd: `almost_full`=1. After the 4th: `out_full`=1, `in_empty`=0, `level`=4.
  - Pop 4 times → 0x11..0x44 in order, then `out_dv`=0, `out_data`=0, `level`=0, no flags.
- Overflow: fill 4, write 0x55 → `ovf`=1, `level`=4; drain → 0x55 never appears. Same cycle: pop+write at full → `level`=3, `ovf`=1, popped 0x11.
- Underflow: empty FIFO, `out_rd_en`=1 with `in_dv`=1 data 0xA5 → `udf`=1, `level`=1, `out_data`=0xA5.
- Streaming wrap: continuous write+pop of incrementing bytes 0x00..0xFF with 2 pre-filled entries → output sequence matches input exactly, `level` stays 2, `ovf`=`udf`=0, pointers wrap 64 times.
- Reset mid-operation: 3 entries stored, assert `rst` asynchronously between edges → outputs go to reset values immediately. After release, write 0x7E → `out_data`=0x7E, `level`=1 (no stale entries).

Source files
------------

// File: rtl/pck_socket_fifo_if.sv
// pck_socket_fifo_if: upstream write link and downstream read link of a PCK socket buffer.
interface pck_socket_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [DATA_WIDTH-1:0] in_data;
  logic in_dv;
  logic in_empty;
  logic [DATA_WIDTH-1:0] out_data;
  logic out_dv;
  logic out_full;
  logic out_rd_en;
  logic [CW-1:0] level;
  logic almost_full;
  logic ovf;
  logic udf;
  modport master (
    output in_data, in_dv, out_rd_en,
    input in_empty, out_data, out_dv, out_full, level, almost_full, ovf, udf
  );
  modport slave (
    input in_data, in_dv, out_rd_en,
    output in_empty, out_data, out_dv, out_full, level, almost_full, ovf, udf
  );
endinterface

// File: rtl/pck_socket_fifo.sv
// pck_socket_fifo: first-word-fall-through socket FIFO with occupancy and sticky ovf/udf flags.
module pck_socket_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input logic clk,
  input logic rst,
  pck_socket_fifo_if.slave s
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic ovf_q, udf_q;
  logic wr, rd;
  assign wr = s.in_dv & s.in_empty;
  assign rd = s.out_rd_en & s.out_dv;
  // every flag comes from the registered count, so no strobe reaches an output combinationally
  assign s.in_empty = cnt < CW'(DEPTH);
  assign s.out_dv = cnt != '0;
  assign s.out_full = cnt == CW'(DEPTH);
  assign s.almost_full = cnt >= CW'(AF_LEVEL);
  assign s.level = cnt;
  assign s.out_data = s.out_dv ? mem[rp] : '0;
  assign s.ovf = ovf_q;
  assign s.udf = udf_q;
  always_ff @(posedge clk) begin
    if (wr && rst) mem[wp] <= s.in_data;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      cnt <= (wr && !rd) ? cnt + CW'(1) : (rd && !wr) ? cnt - CW'(1) : cnt;
      if (s.in_dv && !s.in_empty) ovf_q <= 1'b1;
      if (s.out_rd_en && !s.out_dv) udf_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pck_socket_fifo.sv
// tb_pck_socket_fifo: table vectors plus corner sequences, checked against a queue model.
module tb_pck_socket_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int AF = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  pck_socket_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) s ();
  pck_socket_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (.clk(clk), .rst(rst), .s(s));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q[$];
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;
  typedef struct {
    logic dv;
    logic [7:0] d;
    logic rd;
    logic [2:0] lvl;
    logic dvo;
    logic [7:0] dat;
    logic full;
    logic af;
    logic emp;
    logic ovf;
  } vec_t;
  vec_t tv[9];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = q.size();
    chk({tag, ".level"}, 32'(s.level), 32'(n));
    chk({tag, ".out_dv"}, 32'(s.out_dv), 32'(n != 0));
    chk({tag, ".out_data"}, 32'(s.out_data), n != 0 ? 32'(q[0]) : 32'd0);
    chk({tag, ".out_full"}, 32'(s.out_full), 32'(n == DEPTH));
    chk({tag, ".in_empty"}, 32'(s.in_empty), 32'(n < DEPTH));
    chk({tag, ".almost_full"}, 32'(s.almost_full), 32'(n >= AF));
    chk({tag, ".ovf"}, 32'(s.ovf), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(s.udf), 32'(m_udf));
  endtask

  task automatic cyc(input logic dv, input logic [7:0] d, input logic rd, input string tag);
    logic w, r;
    w = dv && q.size() < DEPTH;
    r = rd && q.size() != 0;
    s.in_dv = dv;
    s.in_data = d;
    s.out_rd_en = rd;
    if (r) chk({tag, ".pop_data"}, 32'(s.out_data), 32'(q.pop_front()));
    if (w) q.push_back(d);
    if (dv && !w) m_ovf = 1'b1;
    if (rd && !r) m_udf = 1'b1;
    @(posedge clk);
    #1;
    s.in_dv = 1'b0;
    s.out_rd_en = 1'b0;
    check_outputs(tag);
  endtask

  task automatic hw_reset();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    tv[0] = '{1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[1] = '{1'b1, 8'h22, 1'b0, 3'd2, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[2] = '{1'b1, 8'h33, 1'b0, 3'd3, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0};
    tv[3] = '{1'b1, 8'h44, 1'b0, 3'd4, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[4] = '{1'b1, 8'h55, 1'b0, 3'd4, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[5] = '{1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1};
    tv[6] = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[7] = '{1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[8] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    s.in_dv = 1'b0;
    s.in_data = '0;
    s.out_rd_en = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      s.in_dv = 1'($urandom);
      s.in_data = 8'($urandom);
      s.out_rd_en = 1'($urandom);
      @(posedge clk);
      #1;
      check_outputs("rst_hold");
    end
    s.in_dv = 1'b0;
    s.out_rd_en = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, "idle");
    for (int i = 0; i < 9; i++) begin
      cyc(tv[i].dv, tv[i].d, tv[i].rd, "vec");
      chk($sformatf("vec%0d.level", i), 32'(s.level), 32'(tv[i].lvl));
      chk($sformatf("vec%0d.out_dv", i), 32'(s.out_dv), 32'(tv[i].dvo));
      chk($sformatf("vec%0d.out_data", i), 32'(s.out_data), 32'(tv[i].dat));
      chk($sformatf("vec%0d.out_full", i), 32'(s.out_full), 32'(tv[i].full));
      chk($sformatf("vec%0d.almost_full", i), 32'(s.almost_full), 32'(tv[i].af));
      chk($sformatf("vec%0d.in_empty", i), 32'(s.in_empty), 32'(tv[i].emp));
      chk($sformatf("vec%0d.ovf", i), 32'(s.ovf), 32'(tv[i].ovf));
    end
    hw_reset();
    cyc(1'b0, 8'h00, 1'b0, "clean_drain");
    chk("clean_drain.flags", 32'({s.ovf, s.udf}), 32'd0);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i * 8'h11), 1'b0, "fill2");
    cyc(1'b1, 8'h66, 1'b1, "full_wr_pop");
    chk("full_wr_pop.level", 32'(s.level), 32'd3);
    chk("full_wr_pop.ovf", 32'(s.ovf), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, "drain2");
    hw_reset();
    cyc(1'b1, 8'hA5, 1'b1, "udf");
    chk("udf.flag", 32'(s.udf), 32'd1);
    chk("udf.level", 32'(s.level), 32'd1);
    chk("udf.data", 32'(s.out_data), 32'hA5);
    hw_reset();
    cyc(1'b1, 8'hF0, 1'b0, "prefill");
    cyc(1'b1, 8'hF1, 1'b0, "prefill");
    for (int i = 0; i < 256; i++) cyc(1'b1, 8'(i), 1'b1, "stream");
    chk("stream.level", 32'(s.level), 32'd2);
    chk("stream.flags", 32'({s.ovf, s.udf}), 32'd0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 8'h00, 1'b1, "stream_tail");
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0, "pre_rst");
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b1, 8'h7E, 1'b0, "post_rst");
    chk("post_rst.data", 32'(s.out_data), 32'h7E);
    chk("post_rst.level", 32'(s.level), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
